// File: rtl/ioctl_pkg.sv
// Shared definitions for the ioctl upload (read-back) responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ioctl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] DEF_UPLOAD_INDEX = 8'd2;
  localparam logic [7:0] DEF_FILL_BYTE    = 8'hFF;

endpackage

// File: rtl/ioctl_upload_reader.sv
// Answers HPS ioctl upload reads by fetching one byte per ioctl_rd from a core-side memory.
// Latency: rd to ioctl_din valid is 3 cycles minimum (grant in first REQ cycle, rvalid next).
// Backpressure: ioctl_wait stalls the HPS while a read is pending; mem_req is held until mem_gnt.
//
// Ports:
//   clk_sys, reset_n                      clock, async active-low reset (memory side shares it)
//   ioctl_upload/index/addr/rd            HPS upload session and read strobe
//   ioctl_din, ioctl_wait                 read data and stall back to the HPS
//   ioctl_upload_req, upload_trigger      core-initiated upload request handshake
//   upload_done                           one-cycle pulse when a matching session ends
//   mem_req/addr/gnt/rvalid/rdata         byte memory read port
module ioctl_upload_reader
  import ioctl_pkg::*;
#(
  parameter logic [7:0] UPLOAD_INDEX = DEF_UPLOAD_INDEX,
  parameter int         ADDR_W       = 14,
  parameter int         MEM_SIZE     = 16384,
  parameter logic [7:0] FILL_BYTE    = DEF_FILL_BYTE
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ioctl_upload_req,
  input  logic              upload_trigger,
  output logic              upload_done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

  state_t              state, state_n;
  logic [7:0]          din_n;
  logic                wait_n;
  logic                mem_req_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic                active;
  logic                active_q;
  logic                in_range;

  assign active = ioctl_upload && (ioctl_index == UPLOAD_INDEX);

  // Full 25-bit compare so high addresses never alias into the memory.
  assign in_range = ({7'd0, ioctl_addr} < MEM_LIMIT);

  always_comb begin
    state_n    = state;
    din_n      = ioctl_din;
    wait_n     = ioctl_wait;
    mem_req_n  = mem_req;
    mem_addr_n = mem_addr;
    case (state)
      IDLE: begin
        if (ioctl_rd && active) begin
          if (in_range) begin
            state_n    = REQ;
            mem_addr_n = ioctl_addr[ADDR_W-1:0];
            mem_req_n  = 1'b1;
            wait_n     = 1'b1;
          end else begin
            din_n = FILL_BYTE;
          end
        end
      end
      REQ: begin
        if (!active) begin
          // A grant in the same cycle still leaves a read in flight that
          // must be absorbed before a new request can start.
          state_n   = mem_gnt ? DRAIN : IDLE;
          mem_req_n = 1'b0;
          wait_n    = 1'b0;
        end else if (mem_gnt) begin
          state_n   = DATA;
          mem_req_n = 1'b0;
        end
      end
      DATA: begin
        if (!active) begin
          // Session lost: release the HPS now; data arriving this very
          // cycle is dropped and the read is already complete.
          state_n = mem_rvalid ? IDLE : DRAIN;
          wait_n  = 1'b0;
        end else if (mem_rvalid) begin
          state_n = IDLE;
          din_n   = mem_rdata;
          wait_n  = 1'b0;
        end
      end
      DRAIN: begin
        if (mem_rvalid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else begin
      state      <= state_n;
      ioctl_din  <= din_n;
      ioctl_wait <= wait_n;
      mem_req    <= mem_req_n;
      mem_addr   <= mem_addr_n;
    end
  end

  // Session edge detection and the core's upload request level.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      active_q         <= 1'b0;
      upload_done      <= 1'b0;
      ioctl_upload_req <= 1'b0;
    end else begin
      active_q    <= active;
      upload_done <= active_q && !active;
      if (active && !active_q)
        ioctl_upload_req <= 1'b0;
      else if (upload_trigger && !active)
        ioctl_upload_req <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Bench for ioctl_upload_reader: table vectors, corner-case sequences, random reads vs. a byte-level model.
// Latency: n/a.
// Backpressure: the memory responder grants and returns data after programmable delays.
module tb_ioctl_upload_reader;

  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic        ioctl_rd;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        ioctl_upload_req;
  logic        upload_trigger;
  logic        upload_done;
  logic        mem_req;
  logic [13:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;

  int checks   = 0;
  int failures = 0;

  // Memory responder configuration and backing store.
  int         gnt_dly = 0;
  int         rv_dly  = 1;
  logic [7:0] mem [0:16383];

  ioctl_upload_reader dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .ioctl_upload_req(ioctl_upload_req), .upload_trigger(upload_trigger),
    .upload_done(upload_done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Memory: grant after gnt_dly cycles of mem_req, data rv_dly cycles after grant.
  initial begin
    bit          pend;
    int          g_cnt;
    int          rv_cnt;
    logic [13:0] p_addr;
    pend = 0; g_cnt = 0; rv_cnt = 0; p_addr = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 8'h00;
    forever begin
      @(posedge clk_sys);
      #2;
      mem_gnt    = 0;
      mem_rvalid = 0;
      if (!reset_n) begin
        pend = 0; g_cnt = 0;
      end else begin
        if (pend) begin
          if (rv_cnt == rv_dly) begin
            mem_rvalid = 1;
            mem_rdata  = mem[p_addr];
            pend       = 0;
          end else begin
            rv_cnt++;
          end
        end
        if (mem_req) begin
          if (g_cnt == gnt_dly) begin
            mem_gnt = 1;
            g_cnt   = 0;
            pend    = 1;
            rv_cnt  = 1;
            p_addr  = mem_addr;
          end else begin
            g_cnt++;
          end
        end else begin
          g_cnt = 0;
        end
      end
    end
  end

  // One HPS read; reports wait cycles, mem_req cycles, address stability and final din.
  task automatic do_read(input bit up, input logic [7:0] idx, input logic [24:0] a, input bit poke,
                         output int wcyc, output int rcyc, output bit addr_ok, output logic [7:0] din);
    bit finished;
    logic [13:0] a_lo;
    a_lo = a[13:0];
    step(); ioctl_upload = up; ioctl_index = idx; ioctl_addr = a;
    step(); ioctl_rd = 1'b1;
    step(); ioctl_rd = 1'b0;
    wcyc = 0; rcyc = 0; addr_ok = 1; finished = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk_sys);
      if (mem_req) begin
        rcyc++;
        if (mem_addr != a_lo) addr_ok = 0;
      end
      if (!ioctl_wait) begin
        finished = 1;
        break;
      end
      wcyc++;
      // A strobe while stalled is a protocol violation and must be ignored.
      if (poke && n == 2) begin #6; ioctl_rd = 1'b1; ioctl_addr = a ^ 25'h1; end
      if (poke && n == 3) begin #6; ioctl_rd = 1'b0; end
    end
    check("rd_complete", 32'(finished), 32'd1);
    din = ioctl_din;
  endtask

  typedef struct {
    bit          up;
    logic [7:0]  idx;
    logic [24:0] addr;
    int          gd;
    int          rd;
    bit          poke;
    int          ew;
    int          er;
    logic [7:0]  ed;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int          wc, rc;
    bit          aok;
    logic [7:0]  d;
    logic [7:0]  exp_din;
    bit          up;
    logic [7:0]  idx;
    logic [24:0] a;
    int          ew, er;

    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[14'h0010] = 8'hA5;
    mem[14'h0011] = 8'h5A;
    mem[14'h0123] = 8'h5C;
    mem[14'h0122] = 8'hC5;
    mem[14'h3FFF] = 8'h11;
    mem[14'h0000] = 8'h3C;

    //               up    idx    addr         gd rd poke ew er din
    tbl[0] = '{1'b1, 8'd2, 25'h0000010, 0, 1, 1'b0, 2, 1, 8'hA5};
    tbl[1] = '{1'b1, 8'd2, 25'h0004000, 0, 1, 1'b0, 0, 0, 8'hFF};
    tbl[2] = '{1'b0, 8'd2, 25'h0000010, 0, 1, 1'b0, 0, 0, 8'hFF};
    tbl[3] = '{1'b1, 8'd2, 25'h0000123, 5, 3, 1'b1, 9, 6, 8'h5C};
    tbl[4] = '{1'b1, 8'd3, 25'h0000010, 0, 1, 1'b0, 0, 0, 8'h5C};
    tbl[5] = '{1'b1, 8'd2, 25'h0003FFF, 2, 2, 1'b0, 5, 3, 8'h11};
    tbl[6] = '{1'b1, 8'd2, 25'h1FFFFFF, 0, 1, 1'b0, 0, 0, 8'hFF};
    tbl[7] = '{1'b1, 8'd2, 25'h0000000, 1, 1, 1'b0, 3, 2, 8'h3C};

    reset_n = 0; ioctl_upload = 0; ioctl_index = 0; ioctl_addr = 0;
    ioctl_rd = 0; upload_trigger = 0;
    #3;
    check("rst_din", 32'(ioctl_din), 32'h00);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_req", 32'(ioctl_upload_req), 32'd0);
    check("rst_done", 32'(upload_done), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    step(); step(); reset_n = 1;

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      gnt_dly = tbl[i].gd; rv_dly = tbl[i].rd;
      do_read(tbl[i].up, tbl[i].idx, tbl[i].addr, tbl[i].poke, wc, rc, aok, d);
      check($sformatf("tbl%0d_wait_cycles", i), 32'(wc), 32'(tbl[i].ew));
      check($sformatf("tbl%0d_req_cycles", i), 32'(rc), 32'(tbl[i].er));
      check($sformatf("tbl%0d_addr_stable", i), 32'(aok), 32'd1);
      check($sformatf("tbl%0d_din", i), 32'(d), 32'(tbl[i].ed));
    end

    // Session lost in DATA: drain outstanding read, ignore rd during drain.
    gnt_dly = 0; rv_dly = 4;
    step(); ioctl_upload = 1; ioctl_index = 8'd2; ioctl_addr = 25'h10;
    step(); ioctl_rd = 1;
    step(); ioctl_rd = 0;
    step(); ioctl_upload = 0;
    step();
    @(negedge clk_sys);
    check("drain_wait_low", 32'(ioctl_wait), 32'd0);
    check("drain_done_pulse", 32'(upload_done), 32'd1);
    step(); ioctl_upload = 1; ioctl_rd = 1;
    step(); ioctl_rd = 0;
    @(negedge clk_sys);
    check("drain_rd_ignored_wait", 32'(ioctl_wait), 32'd0);
    check("drain_rd_ignored_req", 32'(mem_req), 32'd0);
    check("drain_done_single", 32'(upload_done), 32'd0);
    step(); step(); step();
    @(negedge clk_sys);
    check("drain_din_kept", 32'(ioctl_din), 32'h3C);
    gnt_dly = 0; rv_dly = 1;
    do_read(1'b1, 8'd2, 25'h11, 1'b0, wc, rc, aok, d);
    check("after_drain_wait", 32'(wc), 32'd2);
    check("after_drain_din", 32'(d), 32'h5A);

    // Upload request handshake.
    step(); ioctl_upload = 0; ioctl_index = 8'd2;
    step(); upload_trigger = 1;
    step(); upload_trigger = 0;
    @(negedge clk_sys);
    check("req_set", 32'(ioctl_upload_req), 32'd1);
    step(); step(); step();
    @(negedge clk_sys);
    check("req_held", 32'(ioctl_upload_req), 32'd1);
    step(); ioctl_upload = 1; ioctl_index = 8'd3;
    step();
    @(negedge clk_sys);
    check("req_other_index", 32'(ioctl_upload_req), 32'd1);
    step(); ioctl_index = 8'd2;
    step();
    @(negedge clk_sys);
    check("req_cleared", 32'(ioctl_upload_req), 32'd0);
    upload_trigger = 1;
    step(); upload_trigger = 0;
    step();
    @(negedge clk_sys);
    check("req_trigger_active_ignored", 32'(ioctl_upload_req), 32'd0);
    step(); ioctl_upload = 0;
    step();
    @(negedge clk_sys);
    check("done_on_fall", 32'(upload_done), 32'd1);
    step();
    @(negedge clk_sys);
    check("done_one_cycle", 32'(upload_done), 32'd0);

    // Asynchronous reset with request pending and with a read in REQ.
    step(); upload_trigger = 1;
    step(); upload_trigger = 0;
    @(negedge clk_sys);
    check("req_before_reset", 32'(ioctl_upload_req), 32'd1);
    #1 reset_n = 0;
    #1 check("reset_clears_req", 32'(ioctl_upload_req), 32'd0);
    step(); step(); reset_n = 1;
    gnt_dly = 20;
    step(); ioctl_upload = 1; ioctl_index = 8'd2; ioctl_addr = 25'h123;
    step(); ioctl_rd = 1;
    step(); ioctl_rd = 0;
    @(negedge clk_sys);
    check("reset_pre_mem_req", 32'(mem_req), 32'd1);
    #1 reset_n = 0;
    #1;
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_wait", 32'(ioctl_wait), 32'd0);
    check("reset_din", 32'(ioctl_din), 32'h00);
    step(); step(); reset_n = 1;
    gnt_dly = 0; rv_dly = 1;
    do_read(1'b1, 8'd2, 25'h123, 1'b0, wc, rc, aok, d);
    check("post_reset_wait", 32'(wc), 32'd2);
    check("post_reset_din", 32'(d), 32'h5C);

    // Randomized reads against a byte-level model.
    do_read(1'b1, 8'd2, 25'h8000, 1'b0, wc, rc, aok, d);
    check("rand_seed_din", 32'(d), 32'hFF);
    exp_din = 8'hFF;
    for (int i = 0; i < 150; i++) begin
      up  = ($urandom_range(0, 9) != 0);
      idx = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'd2;
      case ($urandom_range(0, 3))
        0:       a = 25'($urandom_range(0, 16383));
        1:       a = 25'($urandom);
        2:       a = 25'(16384 + $urandom_range(0, 3));
        default: a = 25'(16383 - $urandom_range(0, 3));
      endcase
      gnt_dly = $urandom_range(0, 4);
      rv_dly  = $urandom_range(1, 4);
      ew = 0; er = 0;
      if (up && idx == 8'd2) begin
        if (32'(a) < 32'd16384) begin
          er = gnt_dly + 1;
          ew = er + rv_dly;
          exp_din = mem[a[13:0]];
        end else begin
          exp_din = 8'hFF;
        end
      end
      do_read(up, idx, a, 1'b0, wc, rc, aok, d);
      check($sformatf("rand%0d_wait_cycles", i), 32'(wc), 32'(ew));
      check($sformatf("rand%0d_req_cycles", i), 32'(rc), 32'(er));
      check($sformatf("rand%0d_addr_stable", i), 32'(aok), 32'd1);
      check($sformatf("rand%0d_din", i), 32'(d), 32'(exp_din));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
